// File: rtl/long_word_serializer.sv
// Serializes one DATA_W-bit word into NBEATS BEAT_W-bit beats, LSB beat first, with last flag.
// Optional out_parity output (XOR of out_data) enabled by defining LONG_SER_PARITY_EN.
module long_word_serializer #(
    parameter int unsigned DATA_W = 129,
    parameter int unsigned BEAT_W = 64,
    localparam int unsigned NBEATS = (DATA_W + BEAT_W - 1) / BEAT_W,
    localparam int unsigned IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
`ifdef LONG_SER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int unsigned PAD_W = NBEATS * BEAT_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   hold_q, hold_d;
    logic [PAD_W-1:0]   in_pad;
    logic               valid_d;
    logic [BEAT_W-1:0]  data_d;
    logic [IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]   idx_inc;
    logic               last_d;
    logic               beat_done;
    logic               accept;

    // Zero-extended input so the final beat carries zero padding above DATA_W.
    assign in_pad    = PAD_W'(in_data);
    assign idx_inc   = out_idx + IDX_W'(1);
    assign beat_done = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE) | (beat_done & out_last);
    assign accept    = in_valid & in_ready;

    // hold_q keeps the not-yet-presented beats, shifted down so the next beat sits at the bottom.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = out_valid;
        data_d  = out_data;
        idx_d   = out_idx;
        last_d  = out_last;
        if (accept) begin
            state_d = SEND;
            hold_d  = in_pad >> BEAT_W;
            valid_d = 1'b1;
            data_d  = in_pad[BEAT_W-1:0];
            idx_d   = '0;
            last_d  = (NBEATS == 1);
        end else if (beat_done) begin
            if (out_last) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end else begin
                hold_d = hold_q >> BEAT_W;
                data_d = hold_q[BEAT_W-1:0];
                idx_d  = idx_inc;
                last_d = (idx_inc == IDX_W'(NBEATS - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
        end
    end

`ifdef LONG_SER_PARITY_EN
    // Parity tracks data_d so it stays aligned with out_data, including under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else begin
            out_parity <= ^data_d;
        end
    end
`endif

endmodule
